// File: rtl/request_unit.sv
// Memory request unit: arbitrates instruction fetch and data load/store onto one
// shared RAM port, holds strobes until the RAM answers, then pulses ready once.
module request_unit #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_ready,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_ren,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           r_state;
  logic             r_owner_d;
  logic             r_last_d;
  logic [CNT_W-1:0] r_cnt;

  logic             w_d_req;
  logic             w_grant_d;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_timeout;

  // Data wins unless round-robin says the fetch side is owed a turn.
  assign w_d_req    = d_ren | d_wen;
  assign w_grant_d  = w_d_req & ((ARB_MODE == 0) | ~i_req | ~r_last_d);
  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_timeout  = (TIMEOUT > 0) && (w_cnt_next == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_owner_d <= 1'b0;
      r_last_d  <= 1'b0;
      r_cnt     <= '0;
      i_data    <= '0;
      d_rdata   <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_d_req | i_req) begin
            r_state   <= ACCESS;
            busy      <= 1'b1;
            r_cnt     <= '0;
            r_owner_d <= w_grant_d;
            if (w_grant_d) begin
              ram_addr <= d_addr;
              ram_wen  <= d_wen;
              ram_ren  <= ~d_wen;
              if (d_wen) ram_wdata <= d_wdata;
              if (d_ren & d_wen) err <= 1'b1;
            end else begin
              ram_addr <= i_addr;
              ram_ren  <= 1'b1;
              ram_wen  <= 1'b0;
            end
          end
        end

        ACCESS: begin
          if (ram_ready) begin
            if (ram_ren) begin
              if (r_owner_d) d_rdata <= ram_rdata;
              else           i_data  <= ram_rdata;
            end
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            i_ready <= ~r_owner_d;
            d_ready <= r_owner_d;
            r_state <= RESP;
          end else if (w_timeout) begin
            // Abort without touching read data; still answer so the core moves on.
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            err     <= 1'b1;
            i_ready <= ~r_owner_d;
            d_ready <= r_owner_d;
            r_state <= RESP;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        RESP: begin
          i_ready  <= 1'b0;
          d_ready  <= 1'b0;
          busy     <= 1'b0;
          r_last_d <= r_owner_d;
          r_state  <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
